// File: rtl/wake_ctrl_pkg.sv
// Shared types and constants for the wake-word session controller.
package wake_ctrl_pkg;

  typedef enum logic [2:0] {
    StFlush,
    StIdle,
    StCheck,
    StCapture,
    StDeliver
  } state_e;

  // Matches the recognizer history depth so one flush fully clears it.
  localparam int unsigned FLUSH_LEN = 5;
  localparam logic [6:0]  NUL_CHAR  = 7'h00;
  localparam int unsigned FlushCntW = $clog2(FLUSH_LEN);

endpackage

// File: rtl/wake_cmd_buf.sv
// Command character buffer: register array, one write port, combinational read port.
module wake_cmd_buf #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [6:0]       wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [6:0]       rdata_o
);

  logic [6:0] mem_q [Depth];

  // Contents are never reset; the controller's length/read pointer gate every read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wake_session_ctrl.sv
// Sequences the wake-word recognizer, captures the command after a hit and streams it out.
module wake_session_ctrl
  import wake_ctrl_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 16,
  parameter int unsigned TIMEOUT   = 1000,
  parameter logic [6:0]  TERM_CHAR = 7'h0D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [6:0] char_data,
  output logic       char_ready,
  output logic [6:0] rec_ascii,
  output logic       rec_shift,
  input  logic       rec_match,
  output logic       cmd_valid,
  output logic [6:0] cmd_data,
  output logic       cmd_last,
  input  logic       cmd_ready,
  output logic       session_active,
  output logic       tmo_pulse
);

  localparam int unsigned LenW = $clog2(CMD_DEPTH + 1);
  localparam int unsigned RdW  = $clog2(CMD_DEPTH);
  localparam int unsigned TmrW = $clog2(TIMEOUT);

  state_e                 state_q, state_d;
  logic [LenW-1:0]        len_q, len_d;
  logic [RdW-1:0]         rd_q, rd_d;
  logic [TmrW-1:0]        tmr_q, tmr_d;
  logic [FlushCntW-1:0]   fcnt_q, fcnt_d;
  logic                   buf_we;
  logic [6:0]             buf_rdata;

  wake_cmd_buf #(
    .Depth (CMD_DEPTH),
    .AddrW (RdW)
  ) u_cmd_buf (
    .clk_i   (clk),
    .we_i    (buf_we),
    .waddr_i (len_q[RdW-1:0]),
    .wdata_i (char_data),
    .raddr_i (rd_q),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    rd_d           = rd_q;
    tmr_d          = tmr_q;
    fcnt_d         = fcnt_q;
    buf_we         = 1'b0;
    char_ready     = 1'b0;
    rec_ascii      = NUL_CHAR;
    rec_shift      = 1'b0;
    cmd_valid      = 1'b0;
    cmd_data       = NUL_CHAR;
    cmd_last       = 1'b0;
    session_active = 1'b0;
    tmo_pulse      = 1'b0;

    // Outputs fall to their idle values the moment reset asserts, not at the next edge.
    if (rst_n) begin
      unique case (state_q)
        StFlush: begin
          rec_shift = 1'b1;
          if (fcnt_q == FlushCntW'(FLUSH_LEN - 1)) begin
            fcnt_d  = '0;
            state_d = StIdle;
          end else begin
            fcnt_d = fcnt_q + FlushCntW'(1);
          end
        end

        StIdle: begin
          char_ready = 1'b1;
          if (char_valid) begin
            rec_ascii = char_data;
            rec_shift = 1'b1;
            state_d   = StCheck;
          end
        end

        StCheck: begin
          if (rec_match) begin
            state_d = StCapture;
            len_d   = '0;
            tmr_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end

        StCapture: begin
          session_active = 1'b1;
          char_ready     = 1'b1;
          if (char_valid) begin
            tmr_d = '0;
            if (char_data == TERM_CHAR) begin
              state_d = (len_q != '0) ? StDeliver : StFlush;
              rd_d    = '0;
            end else begin
              buf_we = 1'b1;
              len_d  = len_q + LenW'(1);
              if (len_q == LenW'(CMD_DEPTH - 1)) begin
                state_d = StDeliver;
                rd_d    = '0;
              end
            end
          end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
            tmo_pulse = 1'b1;
            state_d   = (len_q != '0) ? StDeliver : StFlush;
            rd_d      = '0;
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end

        StDeliver: begin
          cmd_valid = 1'b1;
          cmd_data  = buf_rdata;
          cmd_last  = (LenW'(rd_q) == len_q - LenW'(1));
          if (cmd_ready) begin
            if (cmd_last) begin
              state_d = StFlush;
            end else begin
              rd_d = rd_q + RdW'(1);
            end
          end
        end

        default: state_d = StFlush;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFlush;
      len_q   <= '0;
      rd_q    <= '0;
      tmr_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      tmr_q   <= tmr_d;
      fcnt_q  <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_wake_session_ctrl.sv
// Directed bench for wake_session_ctrl with a 5-deep stub recognizer matching "Alexa".
module tb_wake_session_ctrl;

  localparam int unsigned CmdDepth = 16;
  localparam int unsigned Timeout  = 8;
  localparam logic [6:0]  Term     = 7'h0D;
  localparam logic [34:0] Alexa    = {7'h41, 7'h6C, 7'h65, 7'h78, 7'h61};

  logic       clk;
  logic       rst_n;
  logic       char_valid;
  logic [6:0] char_data;
  logic       char_ready;
  logic [6:0] rec_ascii;
  logic       rec_shift;
  logic       rec_match;
  logic       cmd_valid;
  logic [6:0] cmd_data;
  logic       cmd_last;
  logic       cmd_ready;
  logic       session_active;
  logic       tmo_pulse;

  int total;
  int bad;

  logic [34:0] hist_q;
  logic [6:0]  wake_str [5];

  wake_session_ctrl #(
    .CMD_DEPTH (CmdDepth),
    .TIMEOUT   (Timeout),
    .TERM_CHAR (Term)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .char_valid     (char_valid),
    .char_data      (char_data),
    .char_ready     (char_ready),
    .rec_ascii      (rec_ascii),
    .rec_shift      (rec_shift),
    .rec_match      (rec_match),
    .cmd_valid      (cmd_valid),
    .cmd_data       (cmd_data),
    .cmd_last       (cmd_last),
    .cmd_ready      (cmd_ready),
    .session_active (session_active),
    .tmo_pulse      (tmo_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub recognizer: shift history on enabled edges, match flag is combinational.
  always @(posedge clk) begin
    if (rec_shift) hist_q <= {hist_q[27:0], rec_ascii};
  end
  assign rec_match = (hist_q == Alexa);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Five flush cycles, then one IDLE check; caller owns char_valid.
  task automatic flush_check(input string tag);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk({tag, "_fl_shift"}, rec_shift, 1'b1);
      chk({tag, "_fl_ascii"}, rec_ascii, 7'h00);
      chk({tag, "_fl_rdy"}, char_ready, 1'b0);
      chk({tag, "_fl_cvalid"}, cmd_valid, 1'b0);
      chk({tag, "_fl_tmo"}, tmo_pulse, 1'b0);
      tick();
    end
    #1;
    chk({tag, "_idle_rdy"}, char_ready, 1'b1);
  endtask

  task automatic wake();
    for (int i = 0; i < 5; i++) begin
      char_valid = 1'b1;
      char_data  = wake_str[i];
      #1;
      chk("wake_shift", rec_shift, 1'b1);
      chk("wake_ascii", rec_ascii, wake_str[i]);
      tick();
      char_valid = 1'b0;
      #1;
      chk("check_rdy", char_ready, 1'b0);
      chk("check_shift", rec_shift, 1'b0);
      tick();
    end
    #1;
    chk("sess_on", session_active, 1'b1);
  endtask

  task automatic send_cap(input logic [6:0] c);
    char_valid = 1'b1;
    char_data  = c;
    #1;
    chk("cap_rdy", char_ready, 1'b1);
    chk("cap_noshift", rec_shift, 1'b0);
    tick();
    char_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    wake_str[0] = 7'h41;
    wake_str[1] = 7'h6C;
    wake_str[2] = 7'h65;
    wake_str[3] = 7'h78;
    wake_str[4] = 7'h61;
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_data  = 7'h00;
    cmd_ready  = 1'b0;

    // Reset values, then release into a 5-cycle flush.
    #3;
    chk("rst_shift", rec_shift, 1'b0);
    chk("rst_rdy", char_ready, 1'b0);
    chk("rst_cvalid", cmd_valid, 1'b0);
    chk("rst_tmo", tmo_pulse, 1'b0);
    tick();
    rst_n = 1'b1;
    flush_check("boot");

    // "Alexa" then "on",CR.
    wake();
    send_cap(7'h6F);
    send_cap(7'h6E);
    send_cap(Term);
    cmd_ready = 1'b1;
    #1;
    chk("d1_valid", cmd_valid, 1'b1);
    chk("d1_sess", session_active, 1'b0);
    chk("d1_data0", cmd_data, 7'h6F);
    chk("d1_last0", cmd_last, 1'b0);
    tick();
    #1;
    chk("d1_data1", cmd_data, 7'h6E);
    chk("d1_last1", cmd_last, 1'b1);
    tick();
    cmd_ready = 1'b0;
    flush_check("d1");

    // Full buffer: 'A'..'P', 17th char held off until IDLE.
    wake();
    for (int i = 0; i < 16; i++) send_cap(7'h41 + 7'(i));
    char_valid = 1'b1;
    char_data  = 7'h51;
    #1;
    chk("full_rdy", char_ready, 1'b0);
    chk("full_valid", cmd_valid, 1'b1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("full_data", cmd_data, 7'h41 + 7'(i));
      chk("full_last", cmd_last, (i == 15));
      chk("full_hold", char_ready, 1'b0);
      tick();
    end
    cmd_ready = 1'b0;
    flush_check("full");
    chk("q_shift", rec_shift, 1'b1);
    chk("q_ascii", rec_ascii, 7'h51);
    tick();
    char_valid = 1'b0;
    #1;
    chk("q_check", char_ready, 1'b0);
    tick();
    #1;
    chk("q_nomatch", char_ready, 1'b1);
    chk("q_nosess", session_active, 1'b0);

    // Char at timer==TIMEOUT-1 wins; then full timeout with one byte.
    wake();
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("tw_notmo", tmo_pulse, 1'b0);
      tick();
    end
    char_valid = 1'b1;
    char_data  = 7'h78;
    #1;
    chk("tw_win", tmo_pulse, 1'b0);
    tick();
    char_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_pulse", tmo_pulse, (i == 7));
      chk("to_sess", session_active, 1'b1);
      tick();
    end
    cmd_ready = 1'b1;
    #1;
    chk("to_valid", cmd_valid, 1'b1);
    chk("to_data", cmd_data, 7'h78);
    chk("to_last", cmd_last, 1'b1);
    tick();
    cmd_ready = 1'b0;
    flush_check("to");

    // Empty session by timeout.
    wake();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("e_pulse", tmo_pulse, (i == 7));
      chk("e_novalid", cmd_valid, 1'b0);
      tick();
    end
    flush_check("e_to");

    // Empty session by immediate terminator.
    wake();
    send_cap(Term);
    flush_check("e_term");

    // Backpressure then reset mid-DELIVER.
    wake();
    send_cap(7'h68);
    send_cap(7'h69);
    send_cap(Term);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", cmd_valid, 1'b1);
      chk("bp_data", cmd_data, 7'h68);
      chk("bp_last", cmd_last, 1'b0);
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    #1;
    chk("bp_data1", cmd_data, 7'h69);
    chk("bp_last1", cmd_last, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", cmd_valid, 1'b0);
    chk("ar_data", cmd_data, 7'h00);
    chk("ar_last", cmd_last, 1'b0);
    chk("ar_rdy", char_ready, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    flush_check("ar");
    chk("ar_novalid", cmd_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
